// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter
// Description : Arbitrates the single register-file write port among the
//               pipeline writeback (WB), the multiply/divide unit (MD) and
//               the load-return path (LD). WB has priority. MD and LD share
//               the port through a round-robin pointer. A starvation counter
//               stalls WB for one cycle when MD/LD have been blocked for too
//               long. A per-register pending scoreboard feeds the read
//               hazard checks.
// Ports       : clk, rst                  - clock, async active-high reset
//               wb_en/wb_add/wb_data      - WB write request
//               md_valid/md_add/md_data   - MD result, md_ready accepts it
//               ld_valid/ld_add/ld_data   - LD result, ld_ready accepts it
//               stall_wb                  - registered WB hold request
//               pend_set/pend_add         - mark a destination pending
//               chk_add1/2, busy1/2       - read hazard checks
//               rf_wr_en/add/data         - registered RF write port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_add,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_add,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_add,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              stall_wb,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_add,
    input  logic [ADDR_W-1:0] chk_add1,
    input  logic [ADDR_W-1:0] chk_add2,
    output logic              busy1,
    output logic              busy2,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_add,
    output logic [DATA_W-1:0] rf_wr_data
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] C_STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    typedef enum logic {
        RR_MD = 1'b0,
        RR_LD = 1'b1
    } rr_t;

    rr_t               r_rr;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_stall_wb;
    logic [NREG-1:0]   r_pend;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_add;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_wb_grant;
    logic              w_md_grant;
    logic              w_ld_grant;
    logic              w_lu_grant;
    logic              w_any_grant;
    logic              w_blocked;
    logic [ADDR_W-1:0] w_win_add;
    logic [DATA_W-1:0] w_win_data;
    logic [NREG-1:0]   w_pend_next;

    // Grants are forced low during reset so no producer sees a handshake
    // that the register stage is about to discard.
    assign w_wb_grant = ~rst & wb_en & ~r_stall_wb;
    assign w_md_grant = ~rst & ~w_wb_grant & md_valid & (~ld_valid | (r_rr == RR_MD));
    assign w_ld_grant = ~rst & ~w_wb_grant & ld_valid & (~md_valid | (r_rr == RR_LD));
    assign w_lu_grant  = w_md_grant | w_ld_grant;
    assign w_any_grant = w_wb_grant | w_lu_grant;
    // A long-latency result is waiting but WB took the port.
    assign w_blocked   = (md_valid | ld_valid) & ~w_lu_grant;

    always_comb begin
        w_win_add  = wb_add;
        w_win_data = wb_data;
        if (w_md_grant) begin
            w_win_add  = md_add;
            w_win_data = md_data;
        end else if (w_ld_grant) begin
            w_win_add  = ld_add;
            w_win_data = ld_data;
        end
    end

    // Clears from accepted transfers are applied first so a same-cycle
    // pend_set to the same register wins.
    always_comb begin
        w_pend_next = r_pend;
        if (w_md_grant) w_pend_next[md_add] = 1'b0;
        if (w_ld_grant) w_pend_next[ld_add] = 1'b0;
        if (pend_set && (pend_add != '0)) w_pend_next[pend_add] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr       <= RR_MD;
            r_wait_cnt <= '0;
            r_stall_wb <= 1'b0;
            r_pend     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_add   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_any_grant & (w_win_add != '0);
            if (w_any_grant) begin
                r_wr_add  <= w_win_add;
                r_wr_data <= w_win_data;
            end

            if (w_md_grant)      r_rr <= RR_LD;
            else if (w_ld_grant) r_rr <= RR_MD;

            if (w_lu_grant)
                r_wait_cnt <= '0;
            else if (w_blocked && (r_wait_cnt != C_STARVE_MAX))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);

            // One-cycle WB hold once the wait count is about to hit the
            // limit; the stall cycle itself always grants MD/LD, so it
            // never needs to be extended.
            r_stall_wb <= ~r_stall_wb & w_blocked & (r_wait_cnt >= C_STARVE_LAST);

            r_pend <= w_pend_next;
        end
    end

    // The registered-write term covers the cycle between acceptance and the
    // register file actually holding the value. r0 is never pending and
    // never written, the explicit address test just makes that obvious.
    assign busy1 = (chk_add1 != '0) &
                   (r_pend[chk_add1] | (r_wr_en & (r_wr_add == chk_add1)));
    assign busy2 = (chk_add2 != '0) &
                   (r_pend[chk_add2] | (r_wr_en & (r_wr_add == chk_add2)));

    assign md_ready   = w_md_grant;
    assign ld_ready   = w_ld_grant;
    assign stall_wb   = r_stall_wb;
    assign rf_wr_en   = r_wr_en;
    assign rf_wr_add  = r_wr_add;
    assign rf_wr_data = r_wr_data;

endmodule
`default_nettype wire
